// File: rtl/muldiv_if.sv
// Request/result bundle for the HI/LO multiply-divide unit.
// The master drives the requests and writes; the slave returns busy, done and HI/LO.
interface muldiv_if;
  logic        valid_in;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output valid_in, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  valid_in, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv.sv
// MIPS-style HI/LO multiply/divide unit: 32-step restoring divide, shift-add or array multiply.
// Define MULDIV_FAST_MUL_EN for a single-cycle array multiply instead of 32 shift-add steps.
module muldiv #(
  parameter logic [31:0] HILO_RESET = 32'h0
) (
  input logic     clk,
  input logic     resetn,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;    // partial product high half / partial remainder
  logic [31:0] low_q, low_d;    // multiplier bits being consumed / dividend becoming quotient
  logic [31:0] opb_q, opb_d;    // multiplicand or divisor magnitude
  logic [31:0] srca_q, srca_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic        is_signed, accept, last;
  logic [31:0] mag_a, mag_b;
  logic [63:0] mul_prod, mul_res;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] div_rem, div_low, quo_res, rem_res;

  assign is_signed = ~bus.op[0];
  assign mag_a     = (is_signed && bus.src_a[31]) ? -bus.src_a : bus.src_a;
  assign mag_b     = (is_signed && bus.src_b[31]) ? -bus.src_b : bus.src_b;
  assign accept    = (state_q == StIdle || state_q == StDone) && bus.valid_in && !bus.flush;
  assign last      = (cnt_q == 6'd31);

`ifdef MULDIV_FAST_MUL_EN
  assign mul_prod = {32'd0, opb_q} * {32'd0, low_q};
`else
  logic [32:0] mul_sum;
  logic [31:0] mul_low;
  assign mul_sum  = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_low  = {mul_sum[0], low_q[31:1]};
  assign mul_prod = {mul_sum[32:1], mul_low};
`endif
  assign mul_res = neg_q ? -mul_prod : mul_prod;

  // Remainder stays below the divisor, so the 32-bit wrapped difference is exact when ge.
  assign rem_sh  = {acc_q, low_q[31]};
  assign ge      = (rem_sh >= {1'b0, opb_q});
  assign div_rem = ge ? (rem_sh[31:0] - opb_q) : rem_sh[31:0];
  assign div_low = {low_q[30:0], ge};
  assign quo_res = dz_q ? 32'hFFFF_FFFF : (neg_q ? -div_low : div_low);
  assign rem_res = dz_q ? srca_q : (rneg_q ? -div_rem : div_rem);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    low_d   = low_q;
    opb_d   = opb_q;
    srca_d  = srca_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (accept) begin
          state_d = bus.op[1] ? StDiv : StMul;
          acc_d   = '0;
          cnt_d   = '0;
          low_d   = bus.op[1] ? mag_a : mag_b;
          opb_d   = bus.op[1] ? mag_b : mag_a;
          srca_d  = bus.src_a;
          neg_d   = is_signed & (bus.src_a[31] ^ bus.src_b[31]);
          rneg_d  = is_signed & bus.src_a[31];
          dz_d    = (bus.src_b == 32'd0);
        end
      end
      StMul: begin
`ifdef MULDIV_FAST_MUL_EN
        state_d      = StDone;
        {hi_d, lo_d} = mul_res;
`else
        acc_d = mul_sum[32:1];
        low_d = mul_low;
        cnt_d = cnt_q + 6'd1;
        if (last) begin
          state_d      = StDone;
          cnt_d        = '0;
          {hi_d, lo_d} = mul_res;
        end
`endif
      end
      StDiv: begin
        acc_d = div_rem;
        low_d = div_low;
        cnt_d = cnt_q + 6'd1;
        if (last) begin
          state_d = StDone;
          cnt_d   = '0;
          hi_d    = rem_res;
          lo_d    = quo_res;
        end
      end
    endcase
    // Abort leaves HI/LO exactly as they were, including any same-cycle write.
    if (bus.flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      acc_q   <= '0;
      low_q   <= '0;
      opb_q   <= '0;
      srca_q  <= '0;
      hi_q    <= HILO_RESET;
      lo_q    <= HILO_RESET;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      low_q   <= low_d;
      opb_q   <= opb_d;
      srca_q  <= srca_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy = (state_q == StMul) || (state_q == StDiv);
  assign bus.done = (state_q == StDone);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv.sv
// Randomized bench for muldiv against a plain-arithmetic HI/LO model.
module tb_muldiv;
  localparam logic [31:0] HiloReset = 32'hA5A5_0F0F;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muldiv_if bus ();
  muldiv #(.HILO_RESET(HiloReset)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {HI, LO} for one operation.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'd0: res = 64'(sa * sb);
      2'd1: res = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = longint'(a) / longint'(b);
          r = longint'(a) % longint'(b);
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit wr);
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.op       = op;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.hi_we    = wr;
    bus.lo_we    = wr;
    bus.wdata    = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.hi_we    = 1'b0;
    bus.lo_we    = 1'b0;
  endtask

  // Waits (bounded) from cycle c0 for done, then checks timing and result.
  task automatic finish_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int c0, input bit b2b);
    logic [63:0] exp;
    int lat;
    int c;
    bit busy_ok;
    exp = model(op, a, b);
    lat = op[1] ? DivLat : MulLat;
    c = c0;
    busy_ok = 1'b1;
    while (!bus.done && c < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      c++;
    end
    check_eq("busy_during_op", 64'(busy_ok), 64'd1);
    check_eq("done_cycle", 64'(c), 64'(lat));
    check_eq("busy_at_done", 64'(bus.busy), 64'd0);
    check_eq("hilo_result", {bus.hi, bus.lo}, exp);
    if (!b2b) begin
      @(posedge clk);
      #1;
      check_eq("done_one_cycle", 64'(bus.done), 64'd0);
      check_eq("hilo_hold", {bus.hi, bus.lo}, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit b2b);
    start_op(op, a, b, 1'b0);
    finish_op(op, a, b, 1, b2b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] prior;
    int c;
    bit saw_done;
    logic [1:0] rop;
    logic [31:0] ra, rb;
    bus.valid_in = 1'b0;
    bus.op       = 2'd0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.flush    = 1'b0;
    bus.hi_we    = 1'b0;
    bus.lo_we    = 1'b0;
    bus.wdata    = '0;
    repeat (3) step();
    check_eq("reset_busy", 64'(bus.busy), 64'd0);
    check_eq("reset_done", 64'(bus.done), 64'd0);
    check_eq("reset_hilo", {bus.hi, bus.lo}, {HiloReset, HiloReset});
    @(negedge clk);
    resetn = 1'b1;

    run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'd3, 32'd7, 32'd0, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b0);

    // MTHI/MTLO while idle
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234_5678;
    step();
    bus.hi_we = 1'b0;
    check_eq("mthi_idle", 64'(bus.hi), 64'h1234_5678);
    @(negedge clk);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h9ABC_DEF0;
    step();
    bus.lo_we = 1'b0;
    check_eq("mtlo_idle", 64'(bus.lo), 64'h9ABC_DEF0);

    // Writes during DIV are dropped
    start_op(2'd2, 32'd100, 32'hFFFF_FFFD, 1'b0);
    step();
    step();
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    step();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check_eq("mt_during_div", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);
    finish_op(2'd2, 32'd100, 32'hFFFF_FFFD, 4, 1'b0);

    // Flush at cycle 10 of DIVU 100/7
    prior = model(2'd2, 32'd100, 32'hFFFF_FFFD);
    start_op(2'd3, 32'd100, 32'd7, 1'b0);
    c = 1;
    while (c < 10) begin
      step();
      c++;
    end
    check_eq("busy_before_flush", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check_eq("flush_busy", 64'(bus.busy), 64'd0);
    check_eq("flush_done", 64'(bus.done), 64'd0);
    check_eq("flush_hilo", {bus.hi, bus.lo}, prior);
    saw_done = 1'b0;
    repeat (30) begin
      step();
      if (bus.done) saw_done = 1'b1;
    end
    check_eq("no_done_after_flush", 64'(saw_done), 64'd0);

    // Flush beats a same-cycle request
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.op       = 2'd1;
    bus.flush    = 1'b1;
    step();
    bus.valid_in = 1'b0;
    bus.flush    = 1'b0;
    check_eq("flush_over_valid", 64'(bus.busy), 64'd0);

    // Write and request in the same cycle: write lands, then the result overwrites it
    start_op(2'd1, 32'd6, 32'd7, 1'b1);
    check_eq("write_with_req", {bus.hi, bus.lo}, 64'h0BAD_F00D_0BAD_F00D);
    finish_op(2'd1, 32'd6, 32'd7, 1, 1'b0);

    // Reset at cycle 5 of a DIV
    start_op(2'd2, 32'd12345, 32'd67, 1'b0);
    repeat (4) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check_eq("rst_mid_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_mid_done", 64'(bus.done), 64'd0);
    check_eq("rst_mid_hilo", {bus.hi, bus.lo}, {HiloReset, HiloReset});
    step();
    check_eq("rst_mid_no_done", 64'(bus.done), 64'd0);
    run_op(2'd3, 32'd12345, 32'd67, 1'b0);

    // Random ops, some issued straight from DONE
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
    end
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have parameter HILO_RESET, default 32'h0, reset value of HI and LO.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port resetn  in  1  synchronous active-low reset.
REQ-004 SHALL have port valid_in  in  1  start request, sampled on clk.
REQ-005 SHALL have port op  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
REQ-006 SHALL have port src_a  in  32  multiplicand / dividend (word_t).
REQ-007 SHALL have port src_b  in  32  multiplier / divisor (word_t).
REQ-008 SHALL have port flush  in  1  abort any in-flight operation.
REQ-009 SHALL have ports hi_we, lo_we  in  1 each  MTHI/MTLO write enables.
REQ-010 SHALL have port wdata  in  32  MTHI/MTLO write data.
REQ-011 SHALL have port busy  out  1  operation in flight; pipeline stalls while high.
REQ-012 SHALL have port done  out  1  one-cycle pulse; hi/lo hold the new result.
REQ-013 SHALL have ports hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV, DONE; DONE SHALL accept requests exactly as IDLE does.
REQ-015 SHALL accept a request when valid_in=1 in IDLE/DONE, capturing op, src_a and src_b, then enter MUL (op 0/1) or DIV (op 2/3).
REQ-016 SHALL ignore valid_in while in MUL or DIV; no queuing.
REQ-017 SHALL drive busy=1 exactly in MUL and DIV; done=1 exactly in DONE.
REQ-018 Divide SHALL use 32 restoring iterations on operand magnitudes: request accepted at cycle 0, DIV occupies cycles 1..32, done=1 at cycle 33.
REQ-019 Signed divide SHALL give quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a); LO=quotient, HI=remainder.
REQ-020 Divide by zero (any signedness) SHALL give LO=32'hFFFFFFFF, HI=src_a.
REQ-021 DIV with 32'h80000000 / 32'hFFFFFFFF SHALL give LO=32'h80000000, HI=0.
REQ-022 Multiply SHALL produce the 64-bit product: signed for MULT, unsigned for MULTU; HI=[63:32], LO=[31:0].
REQ-023 hi/lo SHALL update on the edge entering DONE and hold otherwise, except via REQ-024.
REQ-024 In IDLE/DONE, hi_we/lo_we SHALL write wdata to HI/LO at the next edge; in MUL/DIV they SHALL be ignored.
REQ-025 A write and an accepted request in the same cycle SHALL both take effect; the later result overwrites HI/LO.
REQ-026 flush=1 SHALL force IDLE at the next edge; HI/LO unchanged; no done pulse; flush overrides a same-cycle valid_in.

Reset
REQ-027 With resetn=0 at a clk edge: state=IDLE, busy=0, done=0, hi=lo=HILO_RESET, iteration counter=0.
REQ-028 Reset mid-operation SHALL discard the operation with no done pulse; resetn overrides flush and valid_in.

Configuration
REQ-029 With MULDIV_FAST_MUL_EN defined: single-cycle array multiply; MUL occupies cycle 1 only, done=1 at cycle 2.
REQ-030 Without MULDIV_FAST_MUL_EN: 32-iteration shift-add multiply on magnitudes with sign correction; MUL occupies cycles 1..32, done=1 at cycle 33; results bit-identical to REQ-022.

Verification
REQ-031 MULT a=32'hFFFFFFFE (-2), b=3 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFFA at done; done at cycle 2 (fast) or 33 (iterative).
REQ-032 MULTU a=b=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-033 DIV a=-7 (32'hFFFFFFF9), b=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIVU a=7, b=0 -> LO=32'hFFFFFFFF, HI=7; busy high cycles 1..32, done at cycle 33.
REQ-034 DIVU a=100, b=7 with flush at cycle 10 -> IDLE at cycle 11, busy=0, no done, HI/LO keep prior values.
REQ-035 hi_we=1, wdata=32'h12345678 in IDLE -> hi=32'h12345678 next cycle; same write during DIV -> ignored.
REQ-036 resetn=0 at cycle 5 of a DIV -> next cycle busy=0, done=0, hi=lo=HILO_RESET; a new request after reset completes normally.
